// File: rtl/content_display_pkg.sv
// Shared constants for the multiplexed eight-digit hex display.
// Includes the active-low seven-segment glyph table.
package content_display_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [7:0] AN_OFF     = 8'hFF;

    typedef logic [6:0] glyph_t;

    // Active-low, bit order g..a; letters A, b, C, d, E, F for 10..15.
    localparam glyph_t SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/content_display_if.sv
// Content selection, candidate words and display drive signals of content_display.
interface content_display_if;

    logic [1:0]  sel;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] data3;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [1:0]  shown_sel;

    modport master (
        output sel, data0, data1, data2, data3,
        input  an, seg, shown_sel
    );

    modport slave (
        input  sel, data0, data1, data2, data3,
        output an, seg, shown_sel
    );

endinterface

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment glyph decode.
module hex7seg
    import content_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_LUT[nib];
    end

endmodule

// File: rtl/content_display.sv
// Eight-digit multiplexed hex display with a frame buffer reloaded only at
// frame boundaries, a blanking guard at each slot start, and registered drives.
module content_display
    import content_display_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    content_display_if.slave bus
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic             first_q, first_d;
    logic [31:0]      fbuf_q, fbuf_d;
    logic [1:0]       shown_sel_q, shown_sel_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic             div_wrap;
    logic             frame_start;
    logic [31:0]      sel_word;
    logic [3:0]       nib;
    logic [6:0]       glyph;

    hex7seg u_hex7seg (
        .nib   (nib),
        .seg_n (glyph)
    );

    always_comb begin
        div_wrap    = (div_q == DIV_W'(SCAN_DIV - 1));
        // first_q forces a buffer load on the first edge after reset release.
        frame_start = first_q | (div_wrap & (idx_q == 3'(NUM_DIGITS - 1)));

        unique case (bus.sel)
            2'd0:    sel_word = bus.data0;
            2'd1:    sel_word = bus.data1;
            2'd2:    sel_word = bus.data2;
            default: sel_word = bus.data3;
        endcase

        nib = fbuf_q[{idx_q, 2'b00} +: 4];
    end

    always_comb begin
        div_d       = div_wrap ? '0 : div_q + 1'b1;
        idx_d       = div_wrap ? idx_q + 1'b1 : idx_q;
        first_d     = 1'b0;
        fbuf_d      = frame_start ? sel_word : fbuf_q;
        shown_sel_d = frame_start ? bus.sel  : shown_sel_q;

        // Digit enables stay off for the first GUARD cycles of each slot.
        if (div_q < DIV_W'(GUARD)) begin
            an_d = AN_OFF;
        end else begin
            an_d = ~(8'b1 << idx_q);
        end

        seg_d = {({1'b0, shown_sel_q} != idx_q), glyph};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            idx_q       <= '0;
            first_q     <= 1'b1;
            fbuf_q      <= '0;
            shown_sel_q <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            fbuf_q      <= fbuf_d;
            shown_sel_q <= shown_sel_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.shown_sel = shown_sel_q;

endmodule

// File: tb/tb_content_display.sv
// Directed bench for content_display with SCAN_DIV=4, GUARD=1: scan order,
// tear-free reload, frame-edge selection, async reset and a random sweep.
module tb_content_display;

    localparam int SD = 4;
    localparam int GD = 1;
    localparam int FRAME = SD * 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    content_display_if bus ();

    content_display #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n;
    logic [31:0] exp_fbuf;
    logic [1:0]  exp_ssel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference glyphs written active-high (gfedcba), inverted on return.
    function automatic logic [6:0] ref_glyph(input logic [3:0] v);
        logic [6:0] hi;
        case (v)
            4'h0: hi = 7'h3F;  4'h1: hi = 7'h06;  4'h2: hi = 7'h5B;  4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66;  4'h5: hi = 7'h6D;  4'h6: hi = 7'h7D;  4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F;  4'h9: hi = 7'h6F;  4'hA: hi = 7'h77;  4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39;  4'hD: hi = 7'h5E;  4'hE: hi = 7'h79;  default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    function automatic logic [31:0] word_of(input logic [1:0] s);
        case (s)
            2'd0:    return bus.data0;
            2'd1:    return bus.data1;
            2'd2:    return bus.data2;
            default: return bus.data3;
        endcase
    endfunction

    // One clock edge: predict from the pre-edge scan position, then check.
    task automatic step();
        int          dv;
        int          ix;
        logic [7:0]  e_an;
        logic [7:0]  e_seg;
        logic        load;
        logic [31:0] nw;
        logic [1:0]  ns;
        dv    = n % SD;
        ix    = (n / SD) % 8;
        e_an  = (dv < GD) ? 8'hFF : ~(8'h01 << ix);
        e_seg = {(ix == int'(exp_ssel)) ? 1'b0 : 1'b1, ref_glyph(exp_fbuf[4*ix +: 4])};
        load  = (n == 0) || (((n + 1) % FRAME) == 0);
        ns    = bus.sel;
        nw    = word_of(ns);
        @(posedge clk);
        #1;
        n++;
        chk("an", {24'h0, bus.an}, {24'h0, e_an});
        if (e_an != 8'hFF) chk("seg", {24'h0, bus.seg}, {24'h0, e_seg});
        chk("an_one_low", ($countones(~bus.an) <= 1), 1);
        if (load) begin
            exp_fbuf = nw;
            exp_ssel = ns;
        end
        chk("shown_sel", {30'h0, bus.shown_sel}, {30'h0, exp_ssel});
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.sel   = 2'd0;
        bus.data0 = 32'h76543210;
        bus.data1 = 32'h0;
        bus.data2 = 32'h0;
        bus.data3 = 32'h0;
        n         = 0;
        exp_fbuf  = 32'h0;
        exp_ssel  = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_an",    {24'h0, bus.an},        32'hFF);
        chk("rst_seg",   {24'h0, bus.seg},       32'hFF);
        chk("rst_shown", {30'h0, bus.shown_sel}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int e = 1; e <= 118; e++) begin
            step();
            case (e)
                2:  begin chk("f0_an_e2", {24'h0, bus.an}, 32'hFE); chk("f0_seg_e2", {24'h0, bus.seg}, 32'h40); end
                5:  chk("f0_guard_e5", {24'h0, bus.an}, 32'hFF);
                6:  begin chk("f0_an_e6", {24'h0, bus.an}, 32'hFD); chk("f0_seg_e6", {24'h0, bus.seg}, 32'hF9); end
                12: begin bus.sel = 2'd2; bus.data2 = 32'hDEADBEEF; end
                31: chk("f0_shown_hold", {30'h0, bus.shown_sel}, 32'h0);
                32: chk("f1_shown", {30'h0, bus.shown_sel}, 32'h2);
                36: begin chk("f1_an_e36", {24'h0, bus.an}, 32'hFE); chk("f1_seg_e36", {24'h0, bus.seg}, 32'h8E); end
                42: begin chk("f1_an_e42", {24'h0, bus.an}, 32'hFB); chk("f1_seg_e42", {24'h0, bus.seg}, 32'h06); end
                50: bus.data1 = 32'hCAFE0123;
                63: bus.sel = 2'd1;
                64: chk("edge_sel_shown", {30'h0, bus.shown_sel}, 32'h1);
                66: begin chk("f2_an_e66", {24'h0, bus.an}, 32'hFE); chk("f2_seg_e66", {24'h0, bus.seg}, 32'hB0); end
                80: bus.data1 = 32'h89ABCDEF;
                90: begin chk("f2_an_e90", {24'h0, bus.an}, 32'hBF); chk("f2_seg_e90", {24'h0, bus.seg}, 32'h88); end
                102: begin chk("f3_an_e102", {24'h0, bus.an}, 32'hFD); chk("f3_seg_e102", {24'h0, bus.seg}, 32'h06); end
                default: ;
            endcase
        end

        // Scan is now at idx=5, div=2: reset must blank outputs before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_an",    {24'h0, bus.an},        32'hFF);
        chk("async_seg",   {24'h0, bus.seg},       32'hFF);
        chk("async_shown", {30'h0, bus.shown_sel}, 32'h0);
        bus.sel   = 2'd3;
        bus.data3 = 32'h0F1E2D3C;
        @(posedge clk);
        #1;
        chk("hold_an",  {24'h0, bus.an},  32'hFF);
        chk("hold_seg", {24'h0, bus.seg}, 32'hFF);
        @(negedge clk);
        rst_n    = 1'b1;
        n        = 0;
        exp_fbuf = 32'h0;
        exp_ssel = 2'd0;

        for (int e = 1; e <= 4 * FRAME; e++) begin
            step();
            if (e == 1) chk("rl_shown", {30'h0, bus.shown_sel}, 32'h3);
            if (e == 2) begin
                chk("rl_an_e2",  {24'h0, bus.an},  32'hFE);
                chk("rl_seg_e2", {24'h0, bus.seg}, 32'hC6);
            end
            if (e == 30) begin
                chk("rl_an_e30",  {24'h0, bus.an},  32'h7F);
                chk("rl_seg_e30", {24'h0, bus.seg}, 32'hC0);
            end
            if (e > FRAME) begin
                if ($urandom_range(0, 3) == 0) bus.sel = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 5) == 0) begin
                    bus.data0 = $urandom();
                    bus.data1 = $urandom();
                    bus.data2 = $urandom();
                    bus.data3 = $urandom();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
